// File: rtl/bsg_manycore_sdr_reset_pkg.sv
// rtl/bsg_manycore_sdr_reset_pkg.sv - states, phase count and output decode for the SDR row reset sequencer
package bsg_manycore_sdr_reset_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_TOKEN_HI,
        S_TOKEN_LO,
        S_UPLINK,
        S_DOWNLINK,
        S_DOWNSTREAM,
        S_DONE
    } state_e;

    localparam int unsigned num_phases_lp = 6;

    typedef struct packed {
        logic uplink;
        logic downlink;
        logic downstream;
        logic token;
        logic core;
        logic busy;
        logic done;
    } reset_outs_s;

    // Output levels held for the whole time the sequencer sits in a state.
    function automatic reset_outs_s state_outs(input state_e s);
        reset_outs_s o;
        o.uplink     = 1'b1;
        o.downlink   = 1'b1;
        o.downstream = 1'b1;
        o.token      = 1'b0;
        o.core       = 1'b1;
        o.busy       = 1'b1;
        o.done       = 1'b0;
        case (s)
            S_IDLE:       o.busy = 1'b0;
            S_TOKEN_HI:   o.token = 1'b1;
            S_UPLINK:     o.uplink = 1'b0;
            S_DOWNLINK: begin
                o.uplink   = 1'b0;
                o.downlink = 1'b0;
            end
            S_DOWNSTREAM: begin
                o.uplink     = 1'b0;
                o.downlink   = 1'b0;
                o.downstream = 1'b0;
            end
            S_DONE: begin
                o.uplink     = 1'b0;
                o.downlink   = 1'b0;
                o.downstream = 1'b0;
                o.core       = 1'b0;
                o.busy       = 1'b0;
                o.done       = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bsg_manycore_sdr_reset_step_timer.sv
// rtl/bsg_manycore_sdr_reset_step_timer.sv - loadable down-counter timing one sequencer phase
module bsg_manycore_sdr_reset_step_timer #(
    parameter int lg_step_cycles_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        load_i,
    input  logic [lg_step_cycles_p-1:0] val_i,
    output logic                        expire_o
);

    logic [lg_step_cycles_p-1:0] count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (load_i) begin
            count_r <= val_i;
        end else if (count_r != '0) begin
            count_r <= count_r - 1'b1;
        end
    end

    assign expire_o = (count_r == '0);

endmodule

// File: rtl/bsg_manycore_sdr_reset_sequencer.sv
// rtl/bsg_manycore_sdr_reset_sequencer.sv - ordered reset release for one row of manycore SDR links
module bsg_manycore_sdr_reset_sequencer
    import bsg_manycore_sdr_reset_pkg::*;
#(
    parameter int lg_step_cycles_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [lg_step_cycles_p-1:0] step_cycles_i,
    output logic                        async_uplink_reset_o,
    output logic                        async_downlink_reset_o,
    output logic                        async_downstream_reset_o,
    output logic                        async_token_reset_o,
    output logic                        core_reset_o,
    output logic                        busy_o,
    output logic                        done_o
);

    state_e                      state_r;
    state_e                      next_state;
    reset_outs_s                 outs_r;
    logic [lg_step_cycles_p-1:0] len_m1_r;
    logic [lg_step_cycles_p-1:0] start_len_m1;
    logic                        in_phase;
    logic                        expire;
    logic                        advance;

    // A zero step length is treated as one cycle per phase.
    assign start_len_m1 = (step_cycles_i == '0) ? '0 : step_cycles_i - 1'b1;
    assign in_phase     = (state_r != S_IDLE) && (int'(state_r) <= num_phases_lp);
    assign advance      = in_phase && expire;
    assign next_state   = state_e'(state_r + 3'd1);

    bsg_manycore_sdr_reset_step_timer #(
        .lg_step_cycles_p(lg_step_cycles_p)
    ) step_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (start_i || advance),
        .val_i    (start_i ? start_len_m1 : len_m1_r),
        .expire_o (expire)
    );

    // Outputs decoded from the next state and registered, so the link resets never glitch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= S_IDLE;
            outs_r   <= state_outs(S_IDLE);
            len_m1_r <= '0;
        end else if (start_i) begin
            state_r  <= S_ASSERT;
            outs_r   <= state_outs(S_ASSERT);
            len_m1_r <= start_len_m1;
        end else if (advance) begin
            state_r <= next_state;
            outs_r  <= state_outs(next_state);
        end
    end

    assign async_uplink_reset_o     = outs_r.uplink;
    assign async_downlink_reset_o   = outs_r.downlink;
    assign async_downstream_reset_o = outs_r.downstream;
    assign async_token_reset_o      = outs_r.token;
    assign core_reset_o             = outs_r.core;
    assign busy_o                   = outs_r.busy;
    assign done_o                   = outs_r.done;

endmodule

// File: tb/tb_bsg_manycore_sdr_reset_sequencer.sv
// tb/tb_bsg_manycore_sdr_reset_sequencer.sv - randomized bench against a cycle-count reference model
module tb_bsg_manycore_sdr_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] step_cycles_i = 8'd0;
    logic       up, dn, ds, tok, core, busy, done;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: cycles elapsed since the accepted start and the latched phase length.
    bit m_started = 1'b0;
    int m_k = 0;
    int m_n = 1;

    always #5 clk = ~clk;

    bsg_manycore_sdr_reset_sequencer #(.lg_step_cycles_p(8)) dut (
        .clk_i                    (clk),
        .reset_i                  (reset_i),
        .start_i                  (start_i),
        .step_cycles_i            (step_cycles_i),
        .async_uplink_reset_o     (up),
        .async_downlink_reset_o   (dn),
        .async_downstream_reset_o (ds),
        .async_token_reset_o      (tok),
        .core_reset_o             (core),
        .busy_o                   (busy),
        .done_o                   (done)
    );

    task automatic check_vec(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {up,dn,ds,tok,core,busy,done}=%b expected %b (k=%0d n=%0d)",
                     tag, got, exp, m_k, m_n);
        end
    endtask

    // Phase p = (k-1)/n; each reset is released once enough phases have elapsed.
    function automatic logic [6:0] model_vec();
        int p;
        if (!m_started) return 7'b1110100;
        p = (m_k - 1) / m_n;
        return {p < 3, p < 4, p < 5, p == 1, p < 6, p < 6, p >= 6};
    endfunction

    task automatic tick(input logic r, input logic s, input logic [7:0] st, input string tag);
        @(negedge clk);
        reset_i       = r;
        start_i       = s;
        step_cycles_i = st;
        @(posedge clk);
        if (r) begin
            m_started = 1'b0;
        end else if (s) begin
            m_started = 1'b1;
            m_k       = 1;
            m_n       = (st == 0) ? 1 : int'(st);
        end else if (m_started && m_k < 100000) begin
            m_k++;
        end
        #1;
        check_vec(tag, {up, dn, ds, tok, core, busy, done}, model_vec());
    endtask

    task automatic run_idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++)
            tick(1'b0, 1'b0, 8'($urandom_range(0, 255)), tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'd0, "reset_hold");
        run_idle(20, "idle_hold");

        tick(1'b0, 1'b1, 8'd4, "nominal_start");
        run_idle(30, "nominal");

        tick(1'b0, 1'b1, 8'd4, "restart_from_done");
        run_idle(5, "rerun");
        tick(1'b0, 1'b1, 8'd4, "restart_in_token");
        run_idle(30, "after_token_restart");

        tick(1'b0, 1'b1, 8'd0, "zero_len_start");
        run_idle(10, "zero_len");

        tick(1'b0, 1'b1, 8'd4, "mid_start");
        run_idle(13, "mid_first");
        tick(1'b0, 1'b1, 8'd4, "mid_restart");
        run_idle(30, "mid_second");

        tick(1'b0, 1'b1, 8'd4, "rst_mid_start");
        run_idle(17, "rst_mid_run");
        tick(1'b1, 1'b0, 8'd4, "rst_mid_reset");
        run_idle(20, "rst_mid_no_resume");

        for (int i = 0; i < 3000; i++) begin
            logic r, s;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 39) == 0);
            tick(r, s, 8'($urandom_range(0, 5)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
